// File: rtl/epsilon_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : epsilon_feeder_if
// Brief    : Byte handshake between an entropy source and epsilon_feeder.
// Revision : 1.0 - initial release
// ============================================================================
interface epsilon_feeder_if;
    logic [7:0] byte_dat;
    logic       byte_vld;
    logic       byte_rdy;

    modport master (
        output byte_dat,
        output byte_vld,
        input  byte_rdy
    );

    modport slave (
        input  byte_dat,
        input  byte_vld,
        output byte_rdy
    );
endinterface
`default_nettype wire

// File: rtl/epsilon_feeder.sv
`default_nettype none
// ============================================================================
// Module   : epsilon_feeder
// Brief    : Buffers entropy bytes and serializes them MSB-first, one bit per
//            slot of SLOT_CYCLES clocks, for a downstream monobit test.
// Revision : 1.0 - initial release
// ============================================================================
module epsilon_feeder #(
    parameter int SLOT_CYCLES = 5,
    parameter int BLOCK_BITS  = 128
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    epsilon_feeder_if.slave   byte_if,
    output logic              epsilon_rsc_dat,
    output logic              slot,
    output logic              blk_start,
    output logic [7:0]        underrun_cnt
);

    localparam int                 PHASE_W    = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int                 IDX_W      = (BLOCK_BITS > 1) ? $clog2(BLOCK_BITS) : 1;
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(SLOT_CYCLES - 1);
    localparam logic [1:0]         FIFO_DEPTH = 2'd2;
    localparam logic [3:0]         BYTE_BITS  = 4'd8;
    localparam logic [7:0]         UNDER_MAX  = 8'hFF;

    logic [PHASE_W-1:0] phase_q,      phase_d;
    logic [IDX_W-1:0]   slot_idx_q,   slot_idx_d;
    logic [1:0][7:0]    fifo_mem_q,   fifo_mem_d;
    logic               fifo_wr_ptr_q, fifo_wr_ptr_d;
    logic               fifo_rd_ptr_q, fifo_rd_ptr_d;
    logic [1:0]         fifo_cnt_q,   fifo_cnt_d;
    logic [7:0]         shift_q,      shift_d;
    logic [3:0]         bit_cnt_q,    bit_cnt_d;
    logic [7:0]         underrun_q,   underrun_d;

    logic w_slot;
    logic w_rdy;
    logic w_push;
    logic w_pop;
    logic w_fifo_empty;
    logic w_ser_empty;
    logic w_last_bit;
    logic w_shift;
    logic w_underrun;

    // Handshake and serializer control decoded from current state.
    always_comb begin
        w_slot       = (phase_q == '0);
        w_fifo_empty = (fifo_cnt_q == 2'd0);
        w_ser_empty  = (bit_cnt_q == 4'd0);
        // rdy is gated by rst_n so it drops asynchronously with the reset.
        w_rdy        = rst_n && (fifo_cnt_q != FIFO_DEPTH);
        w_push       = byte_if.byte_vld && w_rdy;
        w_last_bit   = w_slot && (bit_cnt_q == 4'd1);
        // Refill without a gap when the last bit leaves on this slot edge.
        w_pop        = (w_ser_empty || w_last_bit) && !w_fifo_empty;
        w_shift      = w_slot && !w_ser_empty;
        w_underrun   = w_slot && w_ser_empty;
    end

    // Slot timing: phase divider and block position.
    always_comb begin
        phase_d    = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
        slot_idx_d = w_slot ? slot_idx_q + 1'b1 : slot_idx_q;
    end

    // Two-entry FIFO; a pop never sees the byte pushed on the same edge.
    always_comb begin
        fifo_mem_d    = fifo_mem_q;
        fifo_wr_ptr_d = fifo_wr_ptr_q ^ w_push;
        fifo_rd_ptr_d = fifo_rd_ptr_q ^ w_pop;
        fifo_cnt_d    = fifo_cnt_q;
        if (w_push) begin
            fifo_mem_d[fifo_wr_ptr_q] = byte_if.byte_dat;
        end
        case ({w_push, w_pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // Serializer and underrun bookkeeping.
    always_comb begin
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        underrun_d = underrun_q;
        if (w_pop) begin
            shift_d   = fifo_mem_q[fifo_rd_ptr_q];
            bit_cnt_d = BYTE_BITS;
        end else if (w_shift) begin
            shift_d   = {shift_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q - 4'd1;
        end
        if (w_underrun && (underrun_q != UNDER_MAX)) begin
            underrun_d = underrun_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q       <= '0;
            slot_idx_q    <= '0;
            fifo_mem_q    <= '0;
            fifo_wr_ptr_q <= 1'b0;
            fifo_rd_ptr_q <= 1'b0;
            fifo_cnt_q    <= 2'd0;
            shift_q       <= 8'd0;
            bit_cnt_q     <= 4'd0;
            underrun_q    <= 8'd0;
        end else begin
            phase_q       <= phase_d;
            slot_idx_q    <= slot_idx_d;
            fifo_mem_q    <= fifo_mem_d;
            fifo_wr_ptr_q <= fifo_wr_ptr_d;
            fifo_rd_ptr_q <= fifo_rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            underrun_q    <= underrun_d;
        end
    end

    // Outputs are forced low while reset is held.
    always_comb begin
        byte_if.byte_rdy = w_rdy;
        epsilon_rsc_dat  = !w_ser_empty && shift_q[7];
        slot             = rst_n && w_slot;
        blk_start        = rst_n && w_slot && (slot_idx_q == '0);
        underrun_cnt     = underrun_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_epsilon_feeder.sv
`default_nettype none
// Scoreboard bench: stimulus queues the expected value of every slot it cares
// about; per-instance monitors pop and compare whenever slot is high.
module tb_epsilon_feeder;

    typedef struct {
        int cyc;
        bit eps;
        bit blk;
        int ucnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       eps1, slot1, blk1;
    logic [7:0] ucnt1;
    logic       eps2, slot2, blk2;
    logic [7:0] ucnt2;

    exp_t q1[$];
    exp_t q2[$];
    exp_t m1;
    exp_t m2;
    int   cyc1 = 0;
    int   cyc2 = 0;
    int   n_vec = 0;
    int   n_err = 0;

    logic [7:0] b_tbl [4];
    bit         pat_a5 [8];

    always #5 clk = ~clk;

    epsilon_feeder_if bus1();
    epsilon_feeder_if bus2();

    epsilon_feeder #(.SLOT_CYCLES(5), .BLOCK_BITS(128)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .byte_if         (bus1.slave),
        .epsilon_rsc_dat (eps1),
        .slot            (slot1),
        .blk_start       (blk1),
        .underrun_cnt    (ucnt1)
    );

    epsilon_feeder #(.SLOT_CYCLES(3), .BLOCK_BITS(8)) dut_small (
        .clk             (clk),
        .rst_n           (rst_n),
        .byte_if         (bus2.slave),
        .epsilon_rsc_dat (eps2),
        .slot            (slot2),
        .blk_start       (blk2),
        .underrun_cnt    (ucnt2)
    );

    function automatic void check(string name, int act, int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endfunction

    function automatic logic [7:0] feed(int k);
        return 8'((k * 37 + 11) & 255);
    endfunction

    function automatic void push1(int cyc, bit eps, bit blk, int ucnt);
        q1.push_back('{cyc, eps, blk, ucnt});
    endfunction

    function automatic void push2(int cyc, bit eps, bit blk, int ucnt);
        q2.push_back('{cyc, eps, blk, ucnt});
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            cyc1 = 0;
        end else begin
            if (slot1 && q1.size() > 0) begin
                m1 = q1.pop_front();
                n_vec++;
                if (m1.cyc != cyc1 || m1.eps !== eps1 || m1.blk !== blk1 || m1.ucnt != int'(ucnt1)) begin
                    n_err++;
                    $display("FAIL slot_dut: got cyc=%0d eps=%b blk=%b ucnt=%0d, expected cyc=%0d eps=%b blk=%b ucnt=%0d",
                             cyc1, eps1, blk1, ucnt1, m1.cyc, m1.eps, m1.blk, m1.ucnt);
                end
            end
            cyc1++;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            cyc2 = 0;
        end else begin
            if (slot2 && q2.size() > 0) begin
                m2 = q2.pop_front();
                n_vec++;
                if (m2.cyc != cyc2 || m2.eps !== eps2 || m2.blk !== blk2 || m2.ucnt != int'(ucnt2)) begin
                    n_err++;
                    $display("FAIL slot_small: got cyc=%0d eps=%b blk=%b ucnt=%0d, expected cyc=%0d eps=%b blk=%b ucnt=%0d",
                             cyc2, eps2, blk2, ucnt2, m2.cyc, m2.eps, m2.blk, m2.ucnt);
                end
            end
            cyc2++;
        end
    end

    task automatic do_reset();
        rst_n         = 1'b0;
        bus1.byte_vld = 1'b0;
        bus1.byte_dat = 8'h00;
        bus2.byte_vld = 1'b0;
        bus2.byte_dat = 8'h00;
        repeat (3) @(posedge clk);
    endtask

    // Release between edges; the following posedge is edge 0.
    task automatic release_rst();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         idx;
        int         acc_edge [4];
        int         rdy_bad;
        int         rdy41;
        logic       rdy_s;
        logic [7:0] bv;

        b_tbl[0] = 8'h01; b_tbl[1] = 8'h02; b_tbl[2] = 8'h03; b_tbl[3] = 8'h04;
        pat_a5[0] = 1; pat_a5[1] = 0; pat_a5[2] = 1; pat_a5[3] = 0;
        pat_a5[4] = 0; pat_a5[5] = 1; pat_a5[6] = 0; pat_a5[7] = 1;

        // ---- 0xA5 on both instances, then idle ----
        do_reset();
        check("rst_eps",  int'(eps1), 0);
        check("rst_slot", int'(slot1), 0);
        check("rst_blk",  int'(blk1), 0);
        check("rst_ucnt", int'(ucnt1), 0);
        check("rst_rdy",  int'(bus1.byte_rdy), 0);
        push1(0, 0, 1, 0);
        push2(0, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            push1(5 * (i + 1), pat_a5[i], 0, 1);
            push2(3 * (i + 1), pat_a5[i], (i == 7), 1);
        end
        push1(45, 0, 0, 1);
        push1(50, 0, 0, 2);
        push2(27, 0, 0, 1);
        push2(30, 0, 0, 2);
        release_rst();
        bus1.byte_dat = 8'hA5; bus1.byte_vld = 1'b1;
        bus2.byte_dat = 8'hA5; bus2.byte_vld = 1'b1;
        tick();
        check("ucnt_edge0",       int'(ucnt1), 1);
        check("ucnt_edge0_small", int'(ucnt2), 1);
        bus1.byte_vld = 1'b0;
        bus2.byte_vld = 1'b0;
        repeat (55) tick();
        check("a5_drained",       q1.size(), 0);
        check("a5_small_drained", q2.size(), 0);

        // ---- back-pressure with vld held high ----
        do_reset();
        push1(0, 0, 1, 0);
        for (int k = 0; k < 32; k++) begin
            bv = b_tbl[k / 8];
            push1(5 * (k + 1), bv[7 - (k % 8)], 0, 1);
        end
        push1(165, 0, 0, 1);
        push1(170, 0, 0, 2);
        for (int i = 0; i < 4; i++) acc_edge[i] = -1;
        rdy_bad = 0;
        rdy41   = 0;
        idx     = 0;
        release_rst();
        bus1.byte_dat = b_tbl[0];
        bus1.byte_vld = 1'b1;
        for (int e = 0; e < 180; e++) begin
            #1;
            rdy_s = bus1.byte_rdy;
            if (e >= 3 && e <= 40 && rdy_s) rdy_bad++;
            if (e == 41) rdy41 = int'(rdy_s);
            @(posedge clk);
            #1;
            if (rdy_s && bus1.byte_vld) begin
                acc_edge[idx] = e;
                idx++;
                if (idx < 4) bus1.byte_dat = b_tbl[idx];
                else         bus1.byte_vld = 1'b0;
            end
        end
        check("accept_edge0", acc_edge[0], 0);
        check("accept_edge1", acc_edge[1], 1);
        check("accept_edge2", acc_edge[2], 2);
        check("accept_edge3", acc_edge[3], 41);
        check("rdy_low_3_40", rdy_bad, 0);
        check("rdy_high_41",  rdy41, 1);
        check("bp_drained",   q1.size(), 0);

        // ---- continuous feed across block boundaries ----
        do_reset();
        push1(0, 0, 1, 0);
        for (int j = 1; j <= 258; j++) begin
            bv = feed((j - 1) / 8);
            push1(5 * j, bv[7 - ((j - 1) % 8)], (j % 128) == 0, 1);
        end
        idx = 0;
        release_rst();
        bus1.byte_dat = feed(0);
        bus1.byte_vld = 1'b1;
        for (int e = 0; e < 1295; e++) begin
            #1;
            rdy_s = bus1.byte_rdy;
            @(posedge clk);
            #1;
            if (rdy_s) begin
                idx++;
                bus1.byte_dat = feed(idx);
            end
        end
        bus1.byte_vld = 1'b0;
        check("cont_ucnt",    int'(ucnt1), 1);
        check("cont_drained", q1.size(), 0);

        // ---- starvation: saturation at 255 ----
        do_reset();
        for (int j = 0; j <= 300; j++) begin
            push1(5 * j, 0, (j % 128) == 0, (j < 255) ? j : 255);
        end
        release_rst();
        repeat (1505) tick();
        check("sat_ucnt",    int'(ucnt1), 255);
        check("sat_drained", q1.size(), 0);

        // ---- asynchronous reset mid-byte with FIFO full ----
        do_reset();
        push1(0, 0, 1, 0);
        push1(5, 1, 0, 1);
        push1(10, 1, 0, 1);
        release_rst();
        bus1.byte_dat = 8'hFF;
        bus1.byte_vld = 1'b1;
        repeat (3) tick();
        bus1.byte_vld = 1'b0;
        repeat (9) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_eps",  int'(eps1), 0);
        check("arst_slot", int'(slot1), 0);
        check("arst_blk",  int'(blk1), 0);
        check("arst_ucnt", int'(ucnt1), 0);
        check("arst_rdy",  int'(bus1.byte_rdy), 0);
        check("arst_pre_drained", q1.size(), 0);
        repeat (2) @(posedge clk);
        push1(0, 0, 1, 0);
        push1(5, 1, 0, 1);
        for (int i = 2; i <= 8; i++) push1(5 * i, 0, 0, 1);
        push1(45, 0, 0, 1);
        push1(50, 0, 0, 2);
        release_rst();
        bus1.byte_dat = 8'h80;
        bus1.byte_vld = 1'b1;
        #1;
        check("rel_slot", int'(slot1), 1);
        check("rel_blk",  int'(blk1), 1);
        tick();
        bus1.byte_vld = 1'b0;
        repeat (55) tick();
        check("arst_post_drained", q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/epsilon_feeder.md
EPSILON_FEEDER -- requirements
Module: epsilon_feeder

Interface
REQ-001 Parameter SLOT_CYCLES, default 5, clock cycles per bit slot; must equal the cycle count of the downstream monobit test's per-bit FSM loop; legal range 2..16.
REQ-002 Parameter BLOCK_BITS, default 128, bit slots per test block; must be a power of two, 2..128.
REQ-003 clk  input  1  rising-edge clock, single clock domain.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 byte_dat  input  8  raw entropy byte from the upstream source.
REQ-006 byte_vld  input  1  byte_dat valid.
REQ-007 byte_rdy  output  1  feeder can accept a byte this cycle.
REQ-008 epsilon_rsc_dat  output  1  current bit presented to the monobit test.
REQ-009 slot  output  1  high in the cycle the downstream block samples epsilon_rsc_dat (phase 0).
REQ-010 blk_start  output  1  high in the slot cycle carrying the first bit of a block.
REQ-011 underrun_cnt  output  8  saturating count of slots served with no data.

Function
REQ-012 Phase counter 0..SLOT_CYCLES-1: +1 every cycle, wraps to 0; slot = (phase == 0).
REQ-013 Input buffer: 2-entry byte FIFO; byte_rdy = (FIFO count < 2) and not in reset; byte accepted on edge where byte_vld && byte_rdy.
REQ-014 Push and pop on the same edge with count 1: count stays 1, data order preserved; no push possible when full.
REQ-015 Serializer: 8-bit shift register plus bit counter (0..8, 0 = empty); epsilon_rsc_dat = shift register MSB when non-empty, 0 when empty; MSB-first order.
REQ-016 Shift advance: on an edge with slot high and serializer non-empty, shift left one bit and decrement bit counter.
REQ-017 Load: on any edge where serializer is empty, or is consuming its last bit at a slot, and FIFO is non-empty, pop FIFO head into shift register, bit counter = 8.
REQ-018 Latency: byte accepted at edge N into empty FIFO with empty serializer -> its bit 7 on epsilon_rsc_dat after edge N+1; no same-cycle bypass.
REQ-019 Underrun: edge with slot high and serializer empty -> underrun_cnt +1, saturating at 255; epsilon_rsc_dat stays 0 for that slot.
REQ-020 Slot index counter, log2(BLOCK_BITS) bits: +1 on every slot edge, underrun slots included; wraps BLOCK_BITS-1 -> 0.
REQ-021 blk_start = slot && (slot index == 0).
REQ-022 Bytes are never dropped or duplicated; underrun only inserts 0 bits.

Reset
REQ-023 rst_n low -> immediately, independent of clk: phase 0, slot index 0, FIFO empty, serializer empty, underrun_cnt 0, epsilon_rsc_dat 0, byte_rdy 0.
REQ-024 First cycle after rst_n deasserts is phase 0; slot and blk_start are high in that cycle, aligning with a monobit FSM released on the same edge.
REQ-025 Reset mid-byte discards all buffered and partially shifted data; no state survives.

Verification
REQ-026 Release reset, push 0xA5 on edge 0, then byte_vld=0 -> underrun_cnt=1 after edge 0; epsilon at slot edges 5,10,...,40 = 1,0,1,0,0,1,0,1; underrun at edge 45 -> underrun_cnt=2.
REQ-027 byte_vld held high from edge 0 with bytes 0x01,0x02,0x03,0x04 -> accepts at edges 0,1,2; byte_rdy low from edge 2 until the edge after bit 0 of 0x01 is consumed at slot edge 40; bit stream is the byte stream MSB-first, no gaps.
REQ-028 Continuous feed, defaults -> blk_start high at cycles 0, 640, 1280; slot high every 5th cycle; underrun_cnt stays at initial 1.
REQ-029 No input for 300 slots -> underrun_cnt saturates at 255, epsilon_rsc_dat constant 0.
REQ-030 rst_n pulsed low mid-byte with FIFO full -> all outputs 0 asynchronously; after release, phase 0, FIFO empty, next pushed byte serialized from bit 7.
REQ-031 SLOT_CYCLES=3, BLOCK_BITS=8 -> slot every 3rd cycle; blk_start every 24 cycles; REQ-026 sequence reproduced at slot edges 3..24.
